mil_rt_rx_sequencer: RTL

//  Message-level controller behind the Manchester word receiver of the MIL-STD-1553 remote terminal.

---
 rtl/mil_rt_rx_sequencer.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/mil_rt_rx_sequencer.sv
// Message-level receive sequencer for a MIL-STD-1553 remote terminal.
// Decodes command words, steers receive data words into the subaddress
// buffer, and reports completion, errors, transmit and mode requests.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   S_IDLE    | waiting for an accepted command word; data words ignored
//   S_RX_DATA | collecting cmd_wc data words; word gap timer running
module mil_rt_rx_sequencer #(
    parameter logic [4:0] RT_ADDR = 5'd1,
    parameter int         WORD_TO = 1200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_en,
    input  logic        word_stb,
    input  logic        word_is_cw,
    input  logic        word_ok,
    input  logic [15:0] word_data,
    output logic        wr_en,
    output logic [4:0]  wr_addr,
    output logic [4:0]  wr_sa,
    output logic [15:0] wr_data,
    output logic        busy,
    output logic        msg_done,
    output logic        msg_err,
    output logic [1:0]  err_code,
    output logic        bcast,
    output logic        tx_req,
    output logic        mode_req,
    output logic [4:0]  cmd_sa,
    output logic [5:0]  cmd_wc
);

    localparam int             TO_W    = $clog2(WORD_TO + 1);
    // Timeout fires on the edge where the gap counter would reach WORD_TO.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(WORD_TO - 1);

    typedef enum logic {S_IDLE, S_RX_DATA} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [TO_W-1:0] to_q, to_d;
    logic        wr_en_q, wr_en_d;
    logic [4:0]  wr_addr_q, wr_addr_d;
    logic [4:0]  wr_sa_q, wr_sa_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic        msg_done_q, msg_done_d;
    logic        msg_err_q, msg_err_d;
    logic [1:0]  err_code_q, err_code_d;
    logic        bcast_q, bcast_d;
    logic        tx_req_q, tx_req_d;
    logic        mode_req_q, mode_req_d;
    logic [4:0]  cmd_sa_q, cmd_sa_d;
    logic [5:0]  cmd_wc_q, cmd_wc_d;

    logic [4:0] cw_addr, cw_sa, cw_wc;
    logic       cw_tr, cw_is_bcast, cw_accept, cw_is_mode;

    assign cw_addr     = word_data[15:11];
    assign cw_tr       = word_data[10];
    assign cw_sa       = word_data[9:5];
    assign cw_wc       = word_data[4:0];
    assign cw_is_bcast = (cw_addr == 5'd31);
    assign cw_is_mode  = (cw_sa == 5'd0) || (cw_sa == 5'd31);
    assign cw_accept   = word_stb && word_is_cw && word_ok &&
                         ((cw_addr == RT_ADDR) || cw_is_bcast);

    // Next-state and next-output logic for the message sequencer.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        to_d       = to_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_sa_d    = wr_sa_q;
        wr_data_d  = wr_data_q;
        msg_done_d = 1'b0;
        msg_err_d  = 1'b0;
        err_code_d = err_code_q;
        bcast_d    = bcast_q;
        tx_req_d   = 1'b0;
        mode_req_d = 1'b0;
        cmd_sa_d   = cmd_sa_q;
        cmd_wc_d   = cmd_wc_q;

        if (!rx_en) begin
            // Silent drop: no pulses, held outputs untouched.
            state_d = S_IDLE;
            to_d    = '0;
        end else begin
            if (state_q == S_RX_DATA) begin
                if (word_stb && word_is_cw) begin
                    // Any command sync aborts; it is decoded below like one from IDLE.
                    msg_err_d  = 1'b1;
                    err_code_d = 2'd3;
                    state_d    = S_IDLE;
                    to_d       = '0;
                end else if (word_stb) begin
                    // A word arriving on the terminal-count cycle beats the timeout.
                    to_d = '0;
                    if (word_ok) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = cnt_q[4:0];
                        wr_data_d = word_data;
                        cnt_d     = cnt_q + 6'd1;
                        if (cnt_q + 6'd1 == cmd_wc_q) begin
                            msg_done_d = 1'b1;
                            state_d    = S_IDLE;
                        end
                    end else begin
                        msg_err_d  = 1'b1;
                        err_code_d = 2'd1;
                        state_d    = S_IDLE;
                    end
                end else if (to_q == TO_LAST) begin
                    msg_err_d  = 1'b1;
                    err_code_d = 2'd2;
                    state_d    = S_IDLE;
                    to_d       = '0;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end else begin
                to_d = '0;
            end

            if (cw_accept) begin
                if (cw_is_mode) begin
                    cmd_sa_d   = cw_sa;
                    cmd_wc_d   = (cw_wc == 5'd0) ? 6'd32 : {1'b0, cw_wc};
                    bcast_d    = cw_is_bcast;
                    mode_req_d = 1'b1;
                end else if (cw_tr && !cw_is_bcast) begin
                    cmd_sa_d = cw_sa;
                    cmd_wc_d = (cw_wc == 5'd0) ? 6'd32 : {1'b0, cw_wc};
                    bcast_d  = 1'b0;
                    tx_req_d = 1'b1;
                end else if (!cw_tr) begin
                    cmd_sa_d = cw_sa;
                    cmd_wc_d = (cw_wc == 5'd0) ? 6'd32 : {1'b0, cw_wc};
                    bcast_d  = cw_is_bcast;
                    wr_sa_d  = cw_sa;
                    state_d  = S_RX_DATA;
                    cnt_d    = '0;
                    to_d     = '0;
                end
                // Broadcast transmit falls through: not valid for an RT, no effect.
            end
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            to_q       <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_sa_q    <= '0;
            wr_data_q  <= '0;
            msg_done_q <= 1'b0;
            msg_err_q  <= 1'b0;
            err_code_q <= '0;
            bcast_q    <= 1'b0;
            tx_req_q   <= 1'b0;
            mode_req_q <= 1'b0;
            cmd_sa_q   <= '0;
            cmd_wc_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            to_q       <= to_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_sa_q    <= wr_sa_d;
            wr_data_q  <= wr_data_d;
            msg_done_q <= msg_done_d;
            msg_err_q  <= msg_err_d;
            err_code_q <= err_code_d;
            bcast_q    <= bcast_d;
            tx_req_q   <= tx_req_d;
            mode_req_q <= mode_req_d;
            cmd_sa_q   <= cmd_sa_d;
            cmd_wc_q   <= cmd_wc_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_sa    = wr_sa_q;
    assign wr_data  = wr_data_q;
    assign busy     = (state_q == S_RX_DATA);
    assign msg_done = msg_done_q;
    assign msg_err  = msg_err_q;
    assign err_code = err_code_q;
    assign bcast    = bcast_q;
    assign tx_req   = tx_req_q;
    assign mode_req = mode_req_q;
    assign cmd_sa   = cmd_sa_q;
    assign cmd_wc   = cmd_wc_q;

endmodule
